// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with reset vector, stall, relative/absolute jumps
// and call/return through a circular return-address stack.
module pc_sequencer #(
    parameter int unsigned        ADDR_W    = 12,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter int unsigned        RAS_DEPTH = 4,
    localparam int unsigned       CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jump,
    input  logic              jump_abs,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              ras_err
);

    localparam int unsigned      PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_RET,
        OP_CALL,
        OP_JABS,
        OP_JREL,
        OP_SEQ
    } op_e;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    op_e               w_op;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_top;
    logic [PTR_W-1:0]  w_wr_inc;
    logic [PTR_W-1:0]  w_wr_dec;
    logic              w_full;
    logic              w_empty;

    always_comb begin
        w_op = OP_SEQ;
        if (stall)         w_op = OP_HOLD;
        else if (ret)      w_op = OP_RET;
        else if (call)     w_op = OP_CALL;
        else if (jump_abs) w_op = OP_JABS;
        else if (jump)     w_op = OP_JREL;
    end

    // r_wr is the next free slot; the top entry sits one below it, and when full
    // r_wr lands on the oldest entry so a push overwrites it without shifting.
    assign w_wr_inc = (r_wr == PTR_LAST) ? '0 : r_wr + PTR_W'(1);
    assign w_wr_dec = (r_wr == '0) ? PTR_LAST : r_wr - PTR_W'(1);
    assign w_top    = r_ras[w_wr_dec];
    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_full   = (r_count == CNT_FULL);
    assign w_empty  = (r_count == '0);

    always_comb begin
        w_pc_next = r_pc;
        case (w_op)
            OP_HOLD: w_pc_next = r_pc;
            OP_RET:  w_pc_next = w_empty ? w_pc_inc : w_top;
            OP_CALL: w_pc_next = target;
            OP_JABS: w_pc_next = target;
            OP_JREL: w_pc_next = r_pc + offset;
            OP_SEQ:  w_pc_next = w_pc_inc;
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_VEC;
            r_wr    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            case (w_op)
                OP_RET: begin
                    if (w_empty) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wr    <= w_wr_dec;
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                OP_CALL: begin
                    r_wr <= w_wr_inc;
                    if (w_full) r_err <= 1'b1;
                    else        r_count <= r_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_op == OP_CALL) r_ras[r_wr] <= w_pc_inc;
    end

    assign pc        = r_pc;
    assign ras_count = r_count;
    assign ras_full  = w_full;
    assign ras_empty = w_empty;
    assign ras_err   = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table followed by randomized traffic
// checked against a queue-based stack model.
module tb_pc_sequencer;

    localparam int unsigned AW = 12;
    localparam int unsigned D  = 4;

    logic          clk = 1'b0;
    logic          rst, stall, jump, jump_abs, call, ret;
    logic [AW-1:0] offset, target;
    logic [AW-1:0] pc;
    logic [2:0]    ras_count;
    logic          ras_full, ras_empty, ras_err;

    pc_sequencer #(
        .ADDR_W   (AW),
        .RESET_VEC(12'h100),
        .RAS_DEPTH(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .jump     (jump),
        .jump_abs (jump_abs),
        .call     (call),
        .ret      (ret),
        .offset   (offset),
        .target   (target),
        .pc       (pc),
        .ras_count(ras_count),
        .ras_full (ras_full),
        .ras_empty(ras_empty),
        .ras_err  (ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          r, st, rt, cl, ja, jp;
        logic [AW-1:0] off, tgt;
        logic [AW-1:0] epc;
        logic [2:0]    ecnt;
        logic          eerr;
    } vec_t;

    typedef struct {
        string         name;
        logic [AW-1:0] pc;
        logic [2:0]    cnt;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam int NV = 38;
    vec_t tbl [NV];

    // model state for the random phase
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk[$];
    logic          m_err;

    function automatic vec_t mk(input logic r, st, rt, cl, ja, jp,
                                input logic [AW-1:0] off, tgt, epc,
                                input logic [2:0] ecnt, input logic eerr);
        vec_t v;
        v.r = r; v.st = st; v.rt = rt; v.cl = cl; v.ja = ja; v.jp = jp;
        v.off = off; v.tgt = tgt; v.epc = epc; v.ecnt = ecnt; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s %s got %h expected %h", nm, what, got, exp);
        end
    endtask

    task automatic drive(input logic r, st, rt, cl, ja, jp, input logic [AW-1:0] off, tgt);
        rst = r; stall = st; ret = rt; call = cl; jump_abs = ja; jump = jp;
        offset = off; target = tgt;
    endtask

    task automatic step_and_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard empty at time %0t", $time);
        end else begin
            e = sb.pop_front();
            chk(e.name, "pc",    32'(pc),        32'(e.pc));
            chk(e.name, "count", 32'(ras_count), 32'(e.cnt));
            chk(e.name, "full",  32'(ras_full),  32'(e.cnt == 3'(D)));
            chk(e.name, "empty", 32'(ras_empty), 32'(e.cnt == 3'd0));
            chk(e.name, "err",   32'(ras_err),   32'(e.err));
        end
    endtask

    task automatic model_step(input logic r, st, rt, cl, ja, jp, input logic [AW-1:0] off, tgt);
        if (r) begin
            m_pc = 12'h100; m_stk.delete(); m_err = 1'b0;
        end else if (st) begin
        end else if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = m_pc + 12'd1; m_err = 1'b1; end
        end else if (cl) begin
            m_stk.push_back(m_pc + 12'd1);
            if (m_stk.size() > D) begin void'(m_stk.pop_front()); m_err = 1'b1; end
            m_pc = tgt;
        end else if (ja) m_pc = tgt;
        else if (jp)     m_pc = m_pc + off;
        else             m_pc = m_pc + 12'd1;
    endtask

    initial begin
        exp_t e;
        drive(1, 0, 0, 0, 0, 0, '0, '0);
        //              r st rt cl ja jp  off     tgt     pc      cnt err
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h100, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h101, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h102, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h102, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h102, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h103, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1, 0, 12'h000, 12'h010, 12'h010, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 12'hFFC, 12'h000, 12'h00C, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 1, 0, 12'h000, 12'hFFF, 12'hFFF, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 1, 0, 12'h000, 12'h020, 12'h020, 0, 0);
        tbl[11] = mk(0, 0, 0, 1, 0, 0, 12'h000, 12'h300, 12'h300, 1, 0);
        tbl[12] = mk(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h021, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, 0, 12'h000, 12'h400, 12'h400, 0, 0);
        tbl[14] = mk(0, 0, 0, 1, 0, 0, 12'h000, 12'h500, 12'h500, 1, 0);
        tbl[15] = mk(0, 0, 0, 1, 0, 0, 12'h000, 12'h600, 12'h600, 2, 0);
        tbl[16] = mk(0, 0, 0, 1, 0, 0, 12'h000, 12'h700, 12'h700, 3, 0);
        tbl[17] = mk(0, 0, 0, 1, 0, 0, 12'h000, 12'h800, 12'h800, 4, 0);
        tbl[18] = mk(0, 0, 0, 1, 0, 0, 12'h000, 12'h900, 12'h900, 4, 1);
        tbl[19] = mk(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h801, 3, 1);
        tbl[20] = mk(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h701, 2, 1);
        tbl[21] = mk(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h601, 1, 1);
        tbl[22] = mk(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h501, 0, 1);
        tbl[23] = mk(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h502, 0, 1);
        tbl[24] = mk(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h100, 0, 0);
        tbl[25] = mk(0, 0, 0, 0, 1, 0, 12'h000, 12'h040, 12'h040, 0, 0);
        tbl[26] = mk(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h041, 0, 1);
        tbl[27] = mk(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h042, 0, 1);
        tbl[28] = mk(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h100, 0, 0);
        tbl[29] = mk(0, 0, 0, 1, 0, 0, 12'h000, 12'h200, 12'h200, 1, 0);
        tbl[30] = mk(0, 0, 1, 1, 0, 1, 12'h005, 12'h333, 12'h101, 0, 0);
        tbl[31] = mk(0, 0, 0, 1, 0, 0, 12'h000, 12'h200, 12'h200, 1, 0);
        tbl[32] = mk(0, 1, 0, 1, 0, 0, 12'h000, 12'h555, 12'h200, 1, 0);
        tbl[33] = mk(1, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h100, 0, 0);
        tbl[34] = mk(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 12'h101, 0, 1);
        tbl[35] = mk(0, 0, 0, 0, 1, 1, 12'h007, 12'h050, 12'h050, 0, 1);
        tbl[36] = mk(0, 0, 0, 1, 1, 0, 12'h000, 12'h060, 12'h060, 1, 1);
        tbl[37] = mk(0, 0, 0, 0, 0, 1, 12'h010, 12'h000, 12'h070, 1, 1);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].r, tbl[i].st, tbl[i].rt, tbl[i].cl, tbl[i].ja, tbl[i].jp,
                  tbl[i].off, tbl[i].tgt);
            e.name = $sformatf("vec%0d", i);
            e.pc = tbl[i].epc; e.cnt = tbl[i].ecnt; e.err = tbl[i].eerr;
            sb.push_back(e);
            step_and_check();
        end

        m_pc = '0; m_err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic r, st, rt, cl, ja, jp;
            logic [AW-1:0] off, tgt;
            r   = (i == 0) || ($urandom_range(47) == 0);
            st  = ($urandom_range(7) == 0);
            rt  = ($urandom_range(2) == 0);
            cl  = ($urandom_range(2) == 0);
            ja  = ($urandom_range(5) == 0);
            jp  = ($urandom_range(3) == 0);
            off = AW'($urandom);
            tgt = AW'($urandom);
            drive(r, st, rt, cl, ja, jp, off, tgt);
            model_step(r, st, rt, cl, ja, jp, off, tgt);
            e.name = $sformatf("rnd%0d", i);
            e.pc = m_pc; e.cnt = 3'(m_stk.size()); e.err = m_err;
            sb.push_back(e);
            step_and_check();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
